// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the FFT datapath control blocks.
//   LOG2N_DEFAULT  default log2 of the frame length in complex points
//   DATA_WIDTH     width of one real or imaginary data word
//   TWIDDLE_POWER  twiddle scaling exponent (unity = 2**TWIDDLE_POWER)
//   twiddle_t      packed complex twiddle word as read from the ROM
//   seq_state_e    word-phase state of the twiddle sequencer
package fft_pkg;

  localparam int LOG2N_DEFAULT = 6;
  localparam int DATA_WIDTH    = 16;
  localparam int TWIDDLE_POWER = DATA_WIDTH - 1;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } twiddle_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RE   = 2'd1,
    ST_IM   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/twiddle_sequencer_tw_addr_calc.sv
// tw_addr_calc: combinational twiddle exponent for butterfly pair n at stage s.
//   n       pair index within the frame (LOG2N bits)
//   s       FFT stage index
//   tw_addr twiddle ROM address; 0 selects the unity twiddle
// With span L = N >> s and j = n mod L, the lower half of each span uses the
// unity twiddle and the upper half uses exponent (j - L/2) scaled by 2**s.
module tw_addr_calc
  import fft_pkg::*;
#(
  parameter int LOG2N   = LOG2N_DEFAULT,
  parameter int STAGE_W = $clog2(LOG2N)
) (
  input  logic [LOG2N-1:0]   n,
  input  logic [STAGE_W-1:0] s,
  output logic [LOG2N-2:0]   tw_addr
);

  // One bit wider than n so that L = N itself (stage 0) is representable.
  localparam logic [LOG2N:0] N_W   = {1'b1, {LOG2N{1'b0}}};
  localparam logic [LOG2N:0] ONE_W = (LOG2N+1)'(1);

  logic [LOG2N:0] span_w;
  logic [LOG2N:0] half_w;
  logic [LOG2N:0] j_w;

  always_comb begin
    span_w = N_W >> s;
    half_w = span_w >> 1;
    j_w    = {1'b0, n} & (span_w - ONE_W);
    // The scaled exponent is always below N/2, so the narrowing cast is lossless.
    if (j_w >= half_w) begin
      tw_addr = (LOG2N-1)'((j_w - half_w) << s);
    end else begin
      tw_addr = '0;
    end
  end

endmodule

// File: rtl/twiddle_sequencer.sv
// twiddle_sequencer: per-frame control for a word-serial complex rotator.
// Data arrives as re then im words; each complex pair is rotated by a twiddle
// whose ROM address is issued on the re-word cycle.
//   clk, rst      clock, asynchronous active-high reset
//   cfg_start     frame-start pulse, cfg_stage sampled with it
//   in_valid      a data word is present on the rotator input this cycle
//   sw            rotator phase select (high while the im word is accepted)
//   tw_addr       twiddle ROM address, held for the pair's two output cycles
//   out_valid     rotator output valid (real, then imag)
//   busy          frame in progress, through the frame_done cycle
//   frame_done    pulse with the imag output of the last pair
//   err           sticky: bad stage or a gap inside a pair
module twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [$clog2(LOG2N)-1:0]   cfg_stage,
  input  logic                       in_valid,
  output logic                       sw,
  output logic [LOG2N-2:0]           tw_addr,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       err
);

  localparam int               STAGE_W = $clog2(LOG2N);
  localparam logic [LOG2N-1:0] LAST_N  = '1;

  seq_state_e         state_q, state_d;
  logic [LOG2N-1:0]   n_q, n_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [LOG2N-2:0]   tw_addr_q, tw_addr_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               err_q, err_d;
  logic [LOG2N-2:0]   tw_calc;
  logic               stage_ok;

  tw_addr_calc #(
    .LOG2N   (LOG2N),
    .STAGE_W (STAGE_W)
  ) u_tw_addr_calc (
    .n       (n_q),
    .s       (stage_q),
    .tw_addr (tw_calc)
  );

  assign stage_ok = int'(cfg_stage) < LOG2N;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d      = state_q;
    n_d          = n_q;
    stage_d      = stage_q;
    tw_addr_d    = tw_addr_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    busy_d       = busy_q;
    err_d        = err_q;

    // busy covers the frame_done cycle itself, then drops.
    if (frame_done_q) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        // busy_q is still high on the frame_done cycle, so a start there is
        // treated as arriving while busy.
        if (cfg_start && !busy_q) begin
          if (stage_ok) begin
            state_d = ST_RE;
            n_d     = '0;
            stage_d = cfg_stage;
            busy_d  = 1'b1;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RE: begin
        if (in_valid) begin
          state_d     = ST_IM;
          tw_addr_d   = tw_calc;
          out_valid_d = 1'b1;
        end
      end
      ST_IM: begin
        if (in_valid) begin
          out_valid_d = 1'b1;
          n_d         = n_q + 1'b1;
          if (n_q == LAST_N) begin
            state_d      = ST_IDLE;
            frame_done_d = 1'b1;
          end else begin
            state_d = ST_RE;
          end
        end else begin
          // A pair split by a gap cannot be rotated; abandon the frame.
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset branch clears all state asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      n_q          <= '0;
      stage_q      <= '0;
      tw_addr_q    <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      stage_q      <= stage_d;
      tw_addr_q    <= tw_addr_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  // The rotator needs the phase select in the same cycle the im word lands.
  assign sw         = (state_q == ST_IM) && in_valid;
  assign tw_addr    = tw_addr_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
